// File: rtl/counter_pkg.sv
// Shared types and helpers for the up/down modulo counter family.
// The operation encoding is shared so that decode logic and any future users agree on it.
package counter_pkg;

    typedef enum logic [2:0] {
        OP_HOLD,
        OP_CLR,
        OP_LOAD,
        OP_INC,
        OP_DEC
    } cnt_op_e;

    // Widened to 33 bits so a 32-bit counter with modulus 2**32 still compares exactly.
    function automatic logic is_term(input logic [32:0] q,
                                     input logic        up,
                                     input logic [32:0] modulus);
        return up ? (q == (modulus - 33'd1)) : (q == 33'd0);
    endfunction

endpackage

// File: rtl/dff_bank.sv
// Plain D register bank with asynchronous active-high clear to a fixed value.
module dff_bank #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             CLK,
    input  logic             Clear,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    always_ff @(posedge CLK or posedge Clear) begin
        if (Clear) begin
            q_o <= RESET_VAL;
        end else begin
            q_o <= d_i;
        end
    end

endmodule

// File: rtl/updown_mod_counter.sv
// Parametrised synchronous up/down modulo counter with load, sync clear,
// wrap/saturate mode, terminal-count and wrap/load-error event pulses.
module updown_mod_counter
    import counter_pkg::*;
#(
    parameter int     WIDTH     = 8,
    parameter longint MODULUS   = 256,
    parameter bit     SATURATE  = 1'b0,
    parameter longint RESET_VAL = 0
) (
    input  logic             CLK,
    input  logic             Clear,
    input  logic             SyncClr,
    input  logic             Load,
    input  logic [WIDTH-1:0] LoadVal,
    input  logic             En,
    input  logic             Up,
    output logic [WIDTH-1:0] Q,
    output logic             TC,
    output logic             Wrap,
    output logic             LoadErr
);

    localparam int             EW      = WIDTH + 1;
    localparam logic [EW-1:0]  MAX_EXT = EW'(MODULUS - 1);

    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
        $fatal(1, "updown_mod_counter: WIDTH must be in 1..32");
    end
    if (MODULUS < 2 || MODULUS > (longint'(1) << WIDTH)) begin : g_bad_modulus
        $fatal(1, "updown_mod_counter: MODULUS must be in 2..2**WIDTH");
    end
    if (RESET_VAL < 0 || RESET_VAL >= MODULUS) begin : g_bad_reset_val
        $fatal(1, "updown_mod_counter: RESET_VAL must be below MODULUS");
    end

    cnt_op_e          opSel;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             wrap_q;
    logic             wrap_d;
    logic             loadErr_q;
    logic             loadErr_d;
    logic [EW-1:0]    countExt;
    logic [EW-1:0]    loadExt;

    always_comb begin
        opSel = OP_HOLD;
        if (SyncClr) begin
            opSel = OP_CLR;
        end else if (Load) begin
            opSel = OP_LOAD;
        end else if (En) begin
            opSel = Up ? OP_INC : OP_DEC;
        end
    end

    // Range checks run one bit wider than Q so MODULUS == 2**WIDTH needs no special case.
    assign countExt = {1'b0, count_q};
    assign loadExt  = {1'b0, LoadVal};

    always_comb begin
        count_d   = count_q;
        wrap_d    = 1'b0;
        loadErr_d = 1'b0;
        unique case (opSel)
            OP_CLR: begin
                count_d = '0;
            end
            OP_LOAD: begin
                if (loadExt <= MAX_EXT) begin
                    count_d = LoadVal;
                end else begin
                    count_d   = MAX_EXT[WIDTH-1:0];
                    loadErr_d = 1'b1;
                end
            end
            OP_INC: begin
                if (countExt < MAX_EXT) begin
                    count_d = count_q + WIDTH'(1);
                end else if (!SATURATE) begin
                    count_d = '0;
                    wrap_d  = 1'b1;
                end
            end
            OP_DEC: begin
                if (countExt != '0) begin
                    count_d = count_q - WIDTH'(1);
                end else if (!SATURATE) begin
                    count_d = MAX_EXT[WIDTH-1:0];
                    wrap_d  = 1'b1;
                end
            end
            default: begin
                count_d = count_q;
            end
        endcase
    end

    dff_bank #(
        .WIDTH     (WIDTH),
        .RESET_VAL (WIDTH'(RESET_VAL))
    ) u_count (
        .CLK   (CLK),
        .Clear (Clear),
        .d_i   (count_d),
        .q_o   (count_q)
    );

    dff_bank #(
        .WIDTH     (1),
        .RESET_VAL (1'b0)
    ) u_wrap (
        .CLK   (CLK),
        .Clear (Clear),
        .d_i   (wrap_d),
        .q_o   (wrap_q)
    );

    dff_bank #(
        .WIDTH     (1),
        .RESET_VAL (1'b0)
    ) u_load_err (
        .CLK   (CLK),
        .Clear (Clear),
        .d_i   (loadErr_d),
        .q_o   (loadErr_q)
    );

    assign Q       = count_q;
    assign Wrap    = wrap_q;
    assign LoadErr = loadErr_q;
    assign TC      = is_term(33'(count_q), Up, 33'(MODULUS));

endmodule

// File: tb/tb_updown_mod_counter.sv
// Scoreboard bench for updown_mod_counter: four configurations share one control bus,
// gated by a select index; expected responses are queued and checked by a monitor.
module tb_updown_mod_counter;

    typedef struct {
        int         dut;
        logic [7:0] q;
        logic       tc;
        logic       wrap;
        logic       lerr;
        string      name;
    } exp_t;

    logic       clock;
    logic       clear;
    logic       syncClr;
    logic       load;
    logic [7:0] loadVal;
    logic       en;
    logic       up;
    int         sel;

    logic [7:0] q0;
    logic [3:0] q1, q2, q3;
    logic       tc0, tc1, tc2, tc3;
    logic       wr0, wr1, wr2, wr3;
    logic       le0, le1, le2, le3;

    exp_t sbq[$];
    int   totalChecks = 0;
    int   passChecks  = 0;
    int   dutWraps    = 0;
    int   modelWraps  = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    updown_mod_counter u_dut0 (
        .CLK(clock), .Clear(clear),
        .SyncClr(syncClr && sel == 0), .Load(load && sel == 0), .LoadVal(loadVal),
        .En(en && sel == 0), .Up(up),
        .Q(q0), .TC(tc0), .Wrap(wr0), .LoadErr(le0)
    );

    updown_mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0)) u_dut1 (
        .CLK(clock), .Clear(clear),
        .SyncClr(syncClr && sel == 1), .Load(load && sel == 1), .LoadVal(loadVal[3:0]),
        .En(en && sel == 1), .Up(up),
        .Q(q1), .TC(tc1), .Wrap(wr1), .LoadErr(le1)
    );

    updown_mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b1)) u_dut2 (
        .CLK(clock), .Clear(clear),
        .SyncClr(syncClr && sel == 2), .Load(load && sel == 2), .LoadVal(loadVal[3:0]),
        .En(en && sel == 2), .Up(up),
        .Q(q2), .TC(tc2), .Wrap(wr2), .LoadErr(le2)
    );

    updown_mod_counter #(.WIDTH(4), .MODULUS(16), .SATURATE(1'b0)) u_dut3 (
        .CLK(clock), .Clear(clear),
        .SyncClr(syncClr && sel == 3), .Load(load && sel == 3), .LoadVal(loadVal[3:0]),
        .En(en && sel == 3), .Up(up),
        .Q(q3), .TC(tc3), .Wrap(wr3), .LoadErr(le3)
    );

    task automatic pushExp(input int d, input logic [7:0] eq, input logic et,
                           input logic ew, input logic el, input string nm);
        exp_t e;
        e.dut  = d;
        e.q    = eq;
        e.tc   = et;
        e.wrap = ew;
        e.lerr = el;
        e.name = nm;
        sbq.push_back(e);
    endtask

    // Drive one cycle of controls, queue the response expected after the edge,
    // and hold Up steady until the monitor has sampled TC on the falling edge.
    task automatic applyStimulus(input int d, input logic sc, input logic ld,
                                 input logic [7:0] lv, input logic e, input logic u,
                                 input logic [7:0] eq, input logic et, input logic ew,
                                 input logic el, input string nm);
        sel     = d;
        syncClr = sc;
        load    = ld;
        loadVal = lv;
        en      = e;
        up      = u;
        @(posedge clock);
        pushExp(d, eq, et, ew, el, nm);
        @(negedge clock);
        #1;
        syncClr = 1'b0;
        load    = 1'b0;
        en      = 1'b0;
    endtask

    task automatic checkOutput(input exp_t e);
        logic [7:0] aq;
        logic       at, aw, al;
        aq = 8'h00; at = 1'b0; aw = 1'b0; al = 1'b0;
        case (e.dut)
            0:       begin aq = q0;          at = tc0; aw = wr0; al = le0; end
            1:       begin aq = {4'h0, q1};  at = tc1; aw = wr1; al = le1; end
            2:       begin aq = {4'h0, q2};  at = tc2; aw = wr2; al = le2; end
            default: begin aq = {4'h0, q3};  at = tc3; aw = wr3; al = le3; end
        endcase
        if (e.dut == 3 && aw) dutWraps++;
        totalChecks++;
        if ({aq, at, aw, al} === {e.q, e.tc, e.wrap, e.lerr}) begin
            passChecks++;
        end else begin
            $display("[TB] FAIL %s (dut%0d): got q=%h tc=%b wrap=%b lerr=%b, want q=%h tc=%b wrap=%b lerr=%b",
                     e.name, e.dut, aq, at, aw, al, e.q, e.tc, e.wrap, e.lerr);
        end
    endtask

    // Monitor: every falling edge drains whatever responses the stimulus side has queued.
    always @(negedge clock) begin
        while (sbq.size() > 0) begin
            checkOutput(sbq.pop_front());
        end
    end

    initial begin
        int         mq;
        logic       rsc, rld, ren, rup, rw, rtc;
        logic [7:0] rlv;

        clear = 1'b1; syncClr = 1'b0; load = 1'b0; loadVal = 8'h00;
        en = 1'b0; up = 1'b1; sel = 0;
        #3;
        pushExp(0, 8'h00, 1'b0, 1'b0, 1'b0, "reset d0");
        pushExp(1, 8'h00, 1'b0, 1'b0, 1'b0, "reset d1");
        pushExp(2, 8'h00, 1'b0, 1'b0, 1'b0, "reset d2");
        pushExp(3, 8'h00, 1'b0, 1'b0, 1'b0, "reset d3");
        @(negedge clock);
        #1;
        clear = 1'b0;

        // Async clear between edges while the count sits at 0x37
        applyStimulus(0, 0, 1, 8'h37, 0, 1, 8'h37, 0, 0, 0, "load 37");
        @(posedge clock);
        #2;
        clear = 1'b1;
        pushExp(0, 8'h00, 1'b0, 1'b0, 1'b0, "async clear");
        @(negedge clock);
        #1;
        clear = 1'b0;
        applyStimulus(0, 0, 0, 8'h00, 1, 1, 8'h01, 0, 0, 0, "first count after clear");

        // Full-range wrap upward at default modulus
        applyStimulus(0, 0, 1, 8'hFE, 0, 1, 8'hFE, 0, 0, 0, "load FE");
        applyStimulus(0, 0, 0, 8'h00, 1, 1, 8'hFF, 1, 0, 0, "count to FF");
        applyStimulus(0, 0, 0, 8'h00, 1, 1, 8'h00, 0, 1, 0, "wrap to 00");
        applyStimulus(0, 0, 0, 8'h00, 1, 1, 8'h01, 0, 0, 0, "after wrap");

        // Modulus 10, wrapping, counting down and clamped loads
        applyStimulus(1, 0, 1, 8'd1,  0, 0, 8'd1, 0, 0, 0, "m10 load 1");
        applyStimulus(1, 0, 0, 8'd0,  1, 0, 8'd0, 1, 0, 0, "m10 down to 0");
        applyStimulus(1, 0, 0, 8'd0,  1, 0, 8'd9, 0, 1, 0, "m10 wrap down");
        applyStimulus(1, 0, 1, 8'd12, 0, 1, 8'd9, 1, 0, 1, "m10 load 12 clamp");
        applyStimulus(1, 0, 0, 8'd0,  0, 1, 8'd9, 1, 0, 0, "m10 lerr one cycle");
        applyStimulus(1, 0, 1, 8'd15, 1, 1, 8'd9, 1, 0, 1, "m10 load 15 with en");

        // Modulus 10, saturating at both ends
        applyStimulus(2, 0, 1, 8'd8, 0, 1, 8'd8, 0, 0, 0, "sat load 8");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(2, 0, 0, 8'd0, 1, 1, 8'd9, 1, 0, 0, "sat hold 9");
        end
        applyStimulus(2, 0, 1, 8'd0, 0, 0, 8'd0, 1, 0, 0, "sat load 0");
        applyStimulus(2, 0, 0, 8'd0, 1, 0, 8'd0, 1, 0, 0, "sat hold 0");

        // Control priority
        applyStimulus(0, 0, 1, 8'h20, 0, 1, 8'h20, 0, 0, 0, "load 20");
        applyStimulus(0, 1, 1, 8'h55, 1, 1, 8'h00, 0, 0, 0, "syncclr wins");
        applyStimulus(0, 0, 1, 8'h55, 1, 1, 8'h55, 0, 0, 0, "load beats en");
        applyStimulus(0, 1, 0, 8'h00, 0, 0, 8'h00, 1, 0, 0, "syncclr alone");
        applyStimulus(0, 0, 0, 8'h00, 1, 0, 8'hFF, 0, 1, 0, "wrap down to FF");

        // Random traffic on the 4-bit modulo-16 counter against a behavioural model
        applyStimulus(3, 1, 0, 8'h00, 0, 1, 8'h00, 0, 0, 0, "rand sync");
        mq = 0;
        for (int i = 0; i < 10000; i++) begin
            rsc = ($urandom_range(31) == 0);
            rld = ($urandom_range(7) == 0);
            ren = ($urandom_range(3) != 0);
            rup = 1'($urandom_range(1));
            rlv = 8'($urandom_range(255));
            rw  = 1'b0;
            if (rsc) begin
                mq = 0;
            end else if (rld) begin
                mq = int'(rlv[3:0]);
            end else if (ren) begin
                if (rup) begin
                    if (mq == 15) begin mq = 0;  rw = 1'b1; end
                    else          mq = mq + 1;
                end else begin
                    if (mq == 0)  begin mq = 15; rw = 1'b1; end
                    else          mq = mq - 1;
                end
            end
            if (rw) modelWraps++;
            rtc = rup ? (mq == 15) : (mq == 0);
            applyStimulus(3, rsc, rld, rlv, ren, rup, 8'(mq), rtc, rw, 1'b0, "rand");
        end

        repeat (2) @(negedge clock);
        totalChecks++;
        if (dutWraps == modelWraps) begin
            passChecks++;
        end else begin
            $display("[TB] FAIL wrap count: got %0d, want %0d", dutWraps, modelWraps);
        end

        $display("%0d/%0d checks passed", passChecks, totalChecks);
        $finish;
    end

endmodule
